// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - state encoding and default widths shared by the APB master arbiter
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'b00,
    APB_SETUP  = 2'b01,
    APB_ACCESS = 2'b10
  } apb_state_t;

  localparam int APB_NUM_REQ_DEF = 4;
  localparam int APB_ADDR_W_DEF  = 32;
  localparam int APB_DATA_W_DEF  = 32;
  localparam int APB_TIMEOUT_DEF = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick among unmasked requests, searching upward from ptr
module rr_arbiter
  import apb_pkg::*;
#(
  parameter int N = APB_NUM_REQ_DEF
) (
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         mask,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic                 valid
);

  logic [N-1:0] eligible;
  logic         found;

  assign eligible = req & ~mask;
  assign valid    = |eligible;

  // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && eligible[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && eligible[i] && (i < int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin shared APB3 master for NUM_REQ requesters
// Optional ACCESS timeout abort is built only when APB_TIMEOUT_EN is defined.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ        = APB_NUM_REQ_DEF,
  parameter int ADDR_W         = APB_ADDR_W_DEF,
  parameter int DATA_W         = APB_DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEF
) (
  input  logic                      pclk,
  input  logic                      prst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic                      pready,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pslverr
);

  localparam int PW = $clog2(NUM_REQ);

  apb_state_t         state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] arb_mask, arb_grant;
  logic               arb_valid;
  logic               launch;
  logic               abort;

  // The finishing owner may still hold req in its completion cycle, so it is excluded there.
  assign arb_mask = (state_q == APB_ACCESS) ? owner_q : '0;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req   (req),
    .mask  (arb_mask),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q;
    abort = 1'b0;
    if (state_q == APB_SETUP) begin
      tmo_d = '0;
    end else if ((state_q == APB_ACCESS) && !pready) begin
      tmo_d = tmo_q + TW'(1);
      abort = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign abort          = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt_d       = '0;
    done_d      = '0;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    launch      = 1'b0;

    case (state_q)
      APB_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        launch    = arb_valid;
      end
      APB_SETUP: begin
        state_d   = APB_ACCESS;
        penable_d = 1'b1;
      end
      APB_ACCESS: begin
        if (pready) begin
          done_d    = owner_q;
          rsp_err_d = pslverr;
          if (!pwrite_q) rsp_rdata_d = prdata;
          launch    = arb_valid;
          if (!arb_valid) begin
            state_d   = APB_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
          end
        end else if (abort) begin
          // Timed-out transfers never chain into a back-to-back grant.
          done_d    = owner_q;
          rsp_err_d = 1'b1;
          state_d   = APB_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end
      end
      default: begin
        state_d   = APB_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    if (launch) begin
      state_d   = APB_SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      gnt_d     = arb_grant;
      owner_d   = arb_grant;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (arb_grant[i]) begin
          pwrite_d = req_write[i];
          paddr_d  = req_addr[i*ADDR_W +: ADDR_W];
          pwdata_d = req_wdata[i*DATA_W +: DATA_W];
          ptr_d    = PW'((i + 1) % NUM_REQ);
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q     <= APB_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - directed table, back-to-back, reset and random checks against a transaction model
module tb_apb_master_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          pclk = 1'b0;
  logic          prst = 1'b1;
  logic [N-1:0]  req = '0, req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]  gnt, done;
  logic [DW-1:0] rsp_rdata, pwdata, prdata;
  logic [AW-1:0] paddr;
  logic          rsp_err, psel, penable, pwrite, pslverr;
  logic          pready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk), .prst(prst), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  // 32-word slave; out-of-range addresses answer with an error and a marker word.
  logic [DW-1:0] slave_mem [32];
  assign pslverr = psel && penable && (paddr >= 32);
  assign prdata  = (paddr < 32) ? slave_mem[paddr[4:0]] : 32'hDEAD_BEEF;
  always @(posedge pclk) begin
    if (prst) begin
      for (int i = 0; i < 32; i++) slave_mem[i] <= '0;
    end else if (psel && penable && pready && pwrite && (paddr < 32)) begin
      slave_mem[paddr[4:0]] <= pwdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] elig, input int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (elig[idx]) return idx;
    end
    return -1;
  endfunction

  // Transaction-level reference: one outstanding transfer with known grant and completion cycles.
  int            cyc = 0;
  bit            out_busy = 0;
  bit            t_out = 0;
  int            g_cyc, d_cyc, owner, ptr_m = 0;
  int            ws_force = -1;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] model_mem [32];
  logic [DW-1:0] exp_rdata = '0;
  logic [N-1:0]  req_prev = '0, wr_prev = '0;
  logic [N*AW-1:0] addr_prev = '0;
  logic [N*DW-1:0] wdata_prev = '0;
  bit            rst_prev = 1;
  int            gnt_log[$];

  task automatic model_step();
    logic [N-1:0] exp_done, exp_gnt;
    logic         exp_err;
    bit           to_now;
    int           w, ws;
    cyc++;
    if (rst_prev) begin
      chk("reset_outputs", {gnt, done, psel, penable, pwrite, rsp_err, |paddr, |pwdata, |rsp_rdata}, '0);
      out_busy  = 0;
      t_out     = 0;
      ptr_m     = 0;
      exp_rdata = '0;
      for (int i = 0; i < 32; i++) model_mem[i] = '0;
      pready = 1'b0;
    end else begin
      exp_done = '0;
      to_now   = 0;
      if (out_busy && (cyc == d_cyc)) exp_done[owner] = 1'b1;
      chk("done", done, exp_done);
      if (exp_done != '0) begin
        to_now  = t_out;
        exp_err = t_out ? 1'b1 : (m_addr >= 32);
        if (!t_out && !m_write) exp_rdata = (m_addr < 32) ? model_mem[m_addr[4:0]] : 32'hDEAD_BEEF;
        if (!t_out && m_write && (m_addr < 32)) model_mem[m_addr[4:0]] = m_wdata;
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        out_busy = 0;
      end
      exp_gnt = '0;
      if (!out_busy && !to_now) begin
        w = rr_pick(req_prev & ~exp_done, ptr_m);
        if (w >= 0) begin
          exp_gnt[w] = 1'b1;
          owner   = w;
          ptr_m   = (w + 1) % N;
          m_write = wr_prev[w];
          m_addr  = addr_prev[w*AW +: AW];
          m_wdata = wdata_prev[w*DW +: DW];
          ws      = (ws_force >= 0) ? ws_force : $urandom_range(0, 3);
`ifdef APB_TIMEOUT_EN
          if ((ws_force < 0) && ($urandom_range(0, 15) == 0)) ws = TMO + 4;
          t_out = (ws >= TMO);
`else
          t_out = 0;
`endif
          g_cyc    = cyc;
          d_cyc    = t_out ? (cyc + TMO + 1) : (cyc + 2 + ws);
          out_busy = 1;
          gnt_log.push_back(w);
        end
      end
      chk("gnt", gnt, exp_gnt);
      chk("psel", psel, out_busy);
      chk("penable", penable, out_busy && (cyc > g_cyc));
      if (out_busy) chk("command", {pwrite, paddr, pwdata}, {m_write, m_addr, m_wdata});
      pready = out_busy && !t_out && (cyc == d_cyc - 1);
    end
    rst_prev   = prst;
    req_prev   = req;
    wr_prev    = req_write;
    addr_prev  = req_addr;
    wdata_prev = req_wdata;
  endtask

  initial forever begin
    @(negedge pclk);
    model_step();
  end

  // Requesters release req in the cycle their done pulse is seen.
  task automatic tick();
    @(posedge pclk);
    #1;
    req = req & ~done;
  endtask

  typedef struct {
    int            idx;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            ws;
    bit            drop;
    int            lat;
    bit            err;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v);
    int n;
    ws_force = v.ws;
    req_write[v.idx] = v.wr;
    req_addr[v.idx*AW +: AW]  = v.addr;
    req_wdata[v.idx*DW +: DW] = v.wdata;
    req[v.idx] = 1'b1;
    n = 0;
    while (n < 40) begin
      @(posedge pclk);
      #1;
      n++;
      if (done[v.idx]) break;
      if (n == 1) begin
        req_addr[v.idx*AW +: AW]  = ~v.addr;
        req_wdata[v.idx*DW +: DW] = ~v.wdata;
        req_write[v.idx] = ~v.wr;
      end
      if (v.drop && (n == 2)) req[v.idx] = 1'b0;
    end
    chk("vec_latency", n, v.lat);
    chk("vec_rsp_err", rsp_err, v.err);
    chk("vec_rsp_rdata", rsp_rdata, v.rdata);
    req = req & ~done;
    tick();
  endtask

  task automatic apply_reset(input int cycles);
    prst = 1'b1;
    req  = '0;
    repeat (cycles) tick();
    prst = 1'b0;
  endtask

  initial begin
    int n, done_cnt, first_done, last_done, psel_gaps;
    bit started;
    logic [N-1:0] dn;

    vecs.push_back('{0, 1'b1, 32'd5,  32'hA5A5_A5A5, 0, 1'b0, 3, 1'b0, 32'h0000_0000});
    vecs.push_back('{0, 1'b0, 32'd5,  32'h0000_0000, 0, 1'b0, 3, 1'b0, 32'hA5A5_A5A5});
    vecs.push_back('{1, 1'b1, 32'd7,  32'h1234_5678, 3, 1'b1, 6, 1'b0, 32'hA5A5_A5A5});
    vecs.push_back('{2, 1'b1, 32'd40, 32'hFFFF_0000, 0, 1'b0, 3, 1'b1, 32'hA5A5_A5A5});
    vecs.push_back('{3, 1'b0, 32'd7,  32'h0000_0000, 1, 1'b0, 4, 1'b0, 32'h1234_5678});
    vecs.push_back('{1, 1'b0, 32'd39, 32'h0000_0000, 0, 1'b0, 3, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{0, 1'b0, 32'd5,  32'h0000_0000, 2, 1'b0, 5, 1'b0, 32'hA5A5_A5A5});
`ifdef APB_TIMEOUT_EN
    vecs.push_back('{1, 1'b0, 32'd5,  32'h0000_0000, 99, 1'b0, 18, 1'b1, 32'hA5A5_A5A5});
`endif

    apply_reset(3);
    tick();
    foreach (vecs[t]) run_vec(vecs[t]);

    // All four request at once from a fresh pointer.
    apply_reset(2);
    tick();
    ws_force = 0;
    gnt_log.delete();
    for (int i = 0; i < N; i++) begin
      req_write[i] = 1'b1;
      req_addr[i*AW +: AW]  = 32'(10 + i);
      req_wdata[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
    end
    req = '1;
    n = 0; done_cnt = 0; first_done = 0; last_done = 0; psel_gaps = 0; started = 0;
    while ((done_cnt < 4) && (n < 40)) begin
      @(posedge pclk);
      #1;
      n++;
      if (gnt != '0) started = 1;
      if (done != '0) begin
        if (done_cnt == 0) first_done = n;
        last_done = n;
        done_cnt += $countones(done);
      end
      if (started && (done_cnt < 4) && !psel) psel_gaps++;
      req = req & ~done;
    end
    chk("b2b_done_count", done_cnt, 4);
    chk("b2b_grant_count", gnt_log.size(), 4);
    for (int k = 0; k < gnt_log.size(); k++) chk("b2b_grant_order", gnt_log[k], k);
    chk("b2b_psel_gaps", psel_gaps, 0);
    chk("b2b_first_done", first_done, 3);
    chk("b2b_done_span", last_done - first_done, 6);
    tick();

    // Reset while a transfer sits in ACCESS.
    ws_force = 5;
    req_write[2] = 1'b0;
    req_addr[2*AW +: AW] = 32'd3;
    req[2] = 1'b1;
    n = 0;
    while (!penable && (n < 20)) begin
      tick();
      n++;
    end
    chk("mid_reach_access", penable, 1'b1);
    prst = 1'b1;
    req  = '0;
    tick();
    chk("mid_reset_done", done, '0);
    chk("mid_reset_psel", {psel, penable}, '0);
    prst = 1'b0;
    repeat (8) begin
      tick();
      chk("post_reset_no_done", done, '0);
    end

    // Random traffic.
    ws_force = -1;
    repeat (1500) begin
      tick();
      dn = done;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && !dn[i] && ($urandom_range(0, 3) == 0)) begin
          req_write[i] = $urandom_range(0, 1) == 1;
          req_addr[i*AW +: AW]  = 32'($urandom_range(0, 39));
          req_wdata[i*DW +: DW] = $urandom;
          req[i] = 1'b1;
        end else if (req[i] && ($urandom_range(0, 7) == 0)) begin
          req_addr[i*AW +: AW]  = 32'($urandom_range(0, 39));
          req_wdata[i*DW +: DW] = $urandom;
        end
      end
    end
    req = '0;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
